tx_polyphase_interp: RTL and testbench
======================================

# tx_polyphase_interp

Transmit-side polyphase interpolating pulse-shaping filter. It is the transmit counterpart of the receive-side symmetric matched filter. It accepts 1s17 symbols through a ready/valid handshake into a 2-entry buffer and up-samples by UPSAMPLE, producing one filtered 1s17 output per `sam_clk_en`. A single time-shared MAC computes each output. A runtime-writable coefficient bank holds the UPSAMPLE×TAPS_PER_PHASE prototype.

## Interface
- WIDTH, 18, sample and coefficient width
- UPSAMPLE, 4, interpolation factor (outputs per symbol)
- TAPS_PER_PHASE, 4, taps per polyphase branch; prototype length = UPSAMPLE×TAPS_PER_PHASE
- sys_clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- sam_clk_en  in  1  output-sample strobe, one sys_clk wide
- in_data  in  WIDTH  symbol, 1s17
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer not full; reset 1
- coef_wr_en  in  1  coefficient write strobe
- coef_addr  in  clog2(UPSAMPLE×TAPS_PER_PHASE)  coefficient index
- coef_data  in  WIDTH  coefficient, 0s18
- y  out  WIDTH  filtered sample, 1s17; reset 0
- y_valid  out  1  one-cycle pulse when y updates; reset 0
- underflow  out  1  one-cycle pulse: symbol boundary with empty buffer; reset 0
- overrun  out  1  one-cycle pulse: sam_clk_en ignored while busy; reset 0

## Operation
- Input buffer: 2-entry FIFO. Push when in_valid && in_ready. in_ready = not full.
- Phase counter p cycles 0..UPSAMPLE-1 and advances once per accepted sam_clk_en. It wraps to 0.
- Delay line s[0..TAPS_PER_PHASE-1] holds symbols, with s[0] the newest.
- Symbol pop: at an accepted sam_clk_en with p==0, the block shifts the delay line and loads the FIFO head into s[0].
  - If the FIFO is empty, the block loads 0 and pulses underflow.
  - A pop and a push in the same cycle are both honoured.
- Output for phase p: y = sat(Σ_k h[k·UPSAMPLE+p]·s[k]) >> WIDTH, for k = 0..TAPS_PER_PHASE-1.
  - Each product is 2·WIDTH bits (1s35).
  - The accumulator is 2·WIDTH+clog2(TAPS_PER_PHASE) bits.
  - Result is accumulator bits shifted right by WIDTH, truncated (floor), then reduced to WIDTH bits (see Configuration).
- FSM states:
  - IDLE: waits for sam_clk_en. On sam_clk_en it performs the phase/pop actions, clears the accumulator, sets k=0 and goes to MAC.
  - MAC: adds one product per cycle, k = 0..TAPS_PER_PHASE-1, then goes to OUT.
  - OUT: registers y, pulses y_valid, returns to IDLE.
- Any sam_clk_en seen outside IDLE is ignored (no phase advance, no pop) and pulses overrun.
- Coefficient bank: UPSAMPLE×TAPS_PER_PHASE registers, reset to 0.
  - A write takes effect on the next MAC read of that address, with no shadowing. A write mid-computation may therefore affect the current output.
  - coef_wr_en and a MAC read of the same address in the same cycle: the read sees the old value.
- Reset asserted mid-operation: asynchronously empties the FIFO, zeros the delay line and coefficients, sets FSM to IDLE and p=0, and forces all outputs to their reset values.

## Timing
- sam_clk_en sampled at edge E0. MAC steps occur on E1..E(TAPS_PER_PHASE). y and y_valid update at E(TAPS_PER_PHASE+1). Default latency is 5 edges.
- Minimum sam_clk_en spacing is TAPS_PER_PHASE+2 cycles. Closer strobes trigger overrun.
- in_ready falls on the edge that makes the FIFO full, and rises on the edge of the pop.
- y holds its value between y_valid pulses.

## Configuration
- TX_INTERP_SAT_EN defined: the shifted result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- TX_INTERP_SAT_EN undefined: the shifted result wraps (low WIDTH bits kept).

## Test plan
- Reset: assert reset low mid-MAC -> y=0, y_valid=0, in_ready=1, underflow=0, overrun=0 immediately. After release, the first output uses p=0.
- Impulse: write h[a]=4096·a for a=0..15, push 65536 then zeros, strobe sam_clk_en every 8 cycles -> y = 0, 1024, 2048, …, 15360 over 16 outputs. Each y_valid arrives 5 edges after its strobe.
- Underflow: no symbols pushed, 8 strobes -> y=0 every output, underflow pulses on strobes 1 and 5.
- Saturation: all h=131071, push four symbols of -131072, observe the 16th output -> y=-131072 with TX_INTERP_SAT_EN, y=2 without.
- Overrun: strobes 2 cycles apart -> a single y_valid, one overrun pulse, phase advances once.
- Backpressure: push 3 symbols back-to-back with no strobes -> in_ready low after the second push, third symbol held. It is accepted on the cycle after the next p==0 pop.

Source files
------------

// File: rtl/tx_polyphase_interp.sv
// tx_polyphase_interp: transmit polyphase interpolating pulse-shaping filter.
// Symbols (1s17) enter a 2-entry FIFO through ready/valid. Each accepted
// sam_clk_en produces one output phase. One time-shared MAC sums
// TAPS_PER_PHASE products h[k*UPSAMPLE+p]*s[k] and keeps acc >>> WIDTH.
// Build option: define TX_INTERP_SAT_EN to clamp the result to WIDTH bits.
// Without it, the result wraps to its low WIDTH bits.
module tx_polyphase_interp #(
    parameter int WIDTH          = 18,
    parameter int UPSAMPLE       = 4,
    parameter int TAPS_PER_PHASE = 4,
    localparam int NCOEF = UPSAMPLE * TAPS_PER_PHASE,
    localparam int AW    = (NCOEF > 1) ? $clog2(NCOEF) : 1,
    localparam int PW    = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1,
    localparam int KW    = (TAPS_PER_PHASE > 1) ? $clog2(TAPS_PER_PHASE) : 1
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sam_clk_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             coef_wr_en,
    input  logic [AW-1:0]    coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             underflow,
    output logic             overrun
);

    localparam int ACC_W = 2 * WIDTH + KW;
    localparam int SH_W  = ACC_W - WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t                  state_q;
    logic [PW-1:0]           p_q, ph_q;
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [WIDTH-1:0]        y_q, y_d;
    logic                    y_valid_q, underflow_q, overrun_q;
    logic signed [WIDTH-1:0] s_q [TAPS_PER_PHASE];
    logic [WIDTH-1:0]        coef_q [NCOEF];

    logic signed [WIDTH-1:0] fifo_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              cnt_q, cnt_d;
    logic                    accept, push, pop, fifo_empty;

    logic [AW-1:0]           caddr;
    logic signed [2*WIDTH:0] h_ext, s_ext, prod_full;
    logic signed [2*WIDTH-1:0] prod;
    logic                    unused_bits;

    // Result reduction from the shifted accumulator down to WIDTH bits
`ifdef TX_INTERP_SAT_EN
    function automatic logic [WIDTH-1:0] reduce_res(input logic signed [SH_W-1:0] v);
        logic [SH_W-WIDTH:0] hi;
        hi = v[SH_W-1:WIDTH-1];
        if ((&hi) || !(|hi)) return v[WIDTH-1:0];
        else if (v[SH_W-1])  return {1'b1, {(WIDTH-1){1'b0}}};
        else                 return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
    assign y_d = reduce_res(acc_q[ACC_W-1:WIDTH]);
`else
    function automatic logic [WIDTH-1:0] reduce_res(input logic signed [WIDTH-1:0] v);
        return v;
    endfunction
    assign y_d = reduce_res(acc_q[2*WIDTH-1:WIDTH]);
`endif

    assign accept     = sam_clk_en && (state_q == IDLE);
    assign fifo_empty = (cnt_q == 2'd0);
    assign in_ready   = (cnt_q != 2'd2);
    assign push       = in_valid && in_ready;
    assign pop        = accept && (p_q == '0) && !fifo_empty;

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign underflow = underflow_q;
    assign overrun   = overrun_q;

    // Coefficient is unsigned 0s18, symbol is signed 1s17; product fits 1s35
    always_comb begin
        caddr     = AW'(int'(k_q) * UPSAMPLE + int'(ph_q));
        h_ext     = {{(WIDTH+1){1'b0}}, coef_q[caddr]};
        s_ext     = {{(WIDTH+1){s_q[k_q][WIDTH-1]}}, s_q[k_q]};
        prod_full = h_ext * s_ext;
        prod      = prod_full[2*WIDTH-1:0];
    end

    assign unused_bits = ^{acc_q, prod_full[2*WIDTH]};

    // FIFO occupancy next state; simultaneous push and pop leave it unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    // Runtime-writable coefficient bank; MAC reads see the pre-write value
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
        end else if (coef_wr_en) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // Two-entry symbol FIFO
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    // Control FSM: strobe/pop in IDLE, one MAC per cycle, register output in OUT
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            p_q         <= '0;
            ph_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < TAPS_PER_PHASE; i++) s_q[i] <= '0;
        end else begin
            y_valid_q   <= 1'b0;
            underflow_q <= 1'b0;
            overrun_q   <= sam_clk_en && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (sam_clk_en) begin
                        ph_q    <= p_q;
                        p_q     <= (p_q == PW'(UPSAMPLE - 1)) ? '0 : p_q + PW'(1);
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MAC;
                        if (p_q == '0) begin
                            for (int i = TAPS_PER_PHASE - 1; i > 0; i--) s_q[i] <= s_q[i-1];
                            s_q[0]      <= fifo_empty ? '0 : fifo_q[rd_ptr_q];
                            underflow_q <= fifo_empty;
                        end
                    end
                end
                MAC: begin
                    acc_q <= acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
                    if (k_q == KW'(TAPS_PER_PHASE - 1)) state_q <= OUT;
                    else                                k_q     <= k_q + KW'(1);
                end
                OUT: begin
                    y_q       <= y_d;
                    y_valid_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_polyphase_interp.sv
// Directed bench for tx_polyphase_interp: reset, impulse response,
// underflow, overrun, mid-MAC reset, saturation/wrap and backpressure.
module tb_tx_polyphase_interp;

    logic        sys_clk;
    logic        reset;
    logic        sam_clk_en;
    logic [17:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        coef_wr_en;
    logic [3:0]  coef_addr;
    logic [17:0] coef_data;
    logic [17:0] y;
    logic        y_valid;
    logic        underflow;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    tx_polyphase_interp #(.WIDTH(18), .UPSAMPLE(4), .TAPS_PER_PHASE(4)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .y          (y),
        .y_valid    (y_valid),
        .underflow  (underflow),
        .overrun    (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [17:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic strobe();
        sam_clk_en = 1'b1;
        tick();
        sam_clk_en = 1'b0;
    endtask

    // Seven edges after the strobe edge: records the edge index of y_valid
    task automatic collect(output logic signed [31:0] yo, output int lat);
        lat = 0;
        yo  = 0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (y_valid === 1'b1 && lat == 0) begin
                lat = j;
                yo  = $signed(y);
            end
        end
    endtask

    logic signed [31:0] yo;
    int lat, nv, no;
    logic signed [31:0] exp8, exp15;

    initial begin
        reset = 1'b0; sam_clk_en = 1'b0; in_data = '0; in_valid = 1'b0;
        coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0;
`ifdef TX_INTERP_SAT_EN
        exp8 = -131072; exp15 = -131072;
`else
        exp8 = 65537;   exp15 = 2;
`endif
        tick(); tick(); tick();
        check("rst_y", $signed(y), 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_underflow", underflow, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        tick();

        // Impulse: h[a] = 4096*a
        for (int a = 0; a < 16; a++) begin
            coef_wr_en = 1'b1; coef_addr = 4'(a); coef_data = 18'(4096 * a);
            tick();
        end
        coef_wr_en = 1'b0;
        push(18'd65536);
        push(18'd0);
        check("fifo_full_ready", in_ready, 0);
        for (int n = 0; n < 16; n++) begin
            strobe();
            if (n == 0) check("pop_ready_rise", in_ready, 1);
            collect(yo, lat);
            check($sformatf("imp_lat%0d", n), lat, 5);
            check($sformatf("imp_y%0d", n), yo, 1024 * n);
        end

        // Underflow: empty FIFO, eight strobes
        for (int n = 0; n < 8; n++) begin
            strobe();
            check($sformatf("uf_pulse%0d", n), underflow, (n == 0 || n == 4) ? 1 : 0);
            collect(yo, lat);
            check($sformatf("uf_y%0d", n), yo, 0);
        end

        // Overrun: second strobe two cycles after the first
        push(18'd65536);
        strobe();
        tick();
        sam_clk_en = 1'b1;
        tick();
        sam_clk_en = 1'b0;
        check("ovr_pulse", overrun, 1);
        nv = 0; no = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (y_valid === 1'b1) nv++;
            if (overrun === 1'b1) no++;
        end
        check("ovr_one_yvalid", nv, 1);
        check("ovr_no_extra", no, 0);
        strobe();
        collect(yo, lat);
        check("ovr_phase_once", yo, 1024);

        // Reset asserted mid-MAC
        push(18'd5);
        push(18'd6);
        strobe();
        tick();
        sam_clk_en = 1'b1;
        tick();
        sam_clk_en = 1'b0;
        check("mid_pre_overrun", overrun, 1);
        check("mid_pre_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_y", $signed(y), 0);
        check("mid_rst_y_valid", y_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_underflow", underflow, 0);
        check("mid_rst_overrun", overrun, 0);
        #3;
        reset = 1'b1;
        tick();

        // Saturation: all h = 131071, four symbols of -131072
        for (int a = 0; a < 16; a++) begin
            coef_wr_en = 1'b1; coef_addr = 4'(a); coef_data = 18'd131071;
            tick();
        end
        coef_wr_en = 1'b0;
        push(18'h20000);
        push(18'h20000);
        for (int n = 0; n < 16; n++) begin
            strobe();
            if (n == 0) check("post_rst_p0_pop", in_ready, 1);
            collect(yo, lat);
            if (n == 0)  check("sat_y0", yo, -65536);
            if (n == 4)  check("sat_y4", yo, -131071);
            if (n == 8)  check("sat_y8", yo, exp8);
            if (n == 15) check("sat_y15", yo, exp15);
            if (n == 0 || n == 4) push(18'h20000);
        end

        // Backpressure: three back-to-back pushes with no strobes
        in_valid = 1'b1;
        in_data  = 18'd100;
        tick();
        check("bp_after_1", in_ready, 1);
        in_data = 18'd200;
        tick();
        check("bp_after_2", in_ready, 0);
        in_data = 18'd300;
        tick();
        tick();
        check("bp_held", in_ready, 0);
        strobe();
        check("bp_pop_rise", in_ready, 1);
        tick();
        check("bp_third_taken", in_ready, 0);
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
